// File: rtl/cond_flag_unit.sv
// Architectural NZCV flag holder and B.cond resolver: tracks in-flight flag setters,
// stalls a branch until its flags are final, optionally forwarding same-cycle flags.
module cond_flag_unit #(
    parameter int PEND_MAX = 3,
    parameter bit FWD_EN   = 1'b1,
    localparam int CNT_W   = $clog2(PEND_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_we,
    input  logic             negative,
    input  logic             zero,
    input  logic             carry_out,
    input  logic             overflow,
    input  logic             flag_issue,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [3:0]       br_cond,
    output logic             br_ready,
    output logic             taken_valid,
    output logic             taken,
    output logic [3:0]       nzcv,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESOLVE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PEND_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [3:0]       cond_q, cond_d;
    logic             taken_q, taken_d;
    logic             tv_q, tv_d;
    logic             ovf_q, ovf_d;

    logic [3:0] in_flags;
    logic [3:0] eff_flags;
    logic       last_we;
    logic       accept;

    // Flags are packed {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cy;
            4'h3:    return !cy;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cy && !z;
            4'h9:    return !cy || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d = state_q;
        nzcv_d  = nzcv_q;
        pend_d  = pend_q;
        cond_d  = cond_q;
        taken_d = taken_q;
        tv_d    = 1'b0;
        ovf_d   = ovf_q;

        in_flags  = {negative, zero, carry_out, overflow};
        eff_flags = (FWD_EN && flag_we) ? in_flags : nzcv_q;
        last_we   = flag_we && (pend_q <= CNT_ONE);
        br_ready  = (state_q == ST_IDLE) && !flush && !reset;
        accept    = br_valid && br_ready;

        if (flag_we) nzcv_d = in_flags;

        // A saturated issue holds the count; the sticky error records the lost setter.
        if (flag_issue && !flag_we && pend_q == CNT_MAX) ovf_d = 1'b1;

        if (flush) begin
            pend_d = '0;
        end else if (flag_issue && !flag_we) begin
            if (pend_q != CNT_MAX) pend_d = pend_q + CNT_ONE;
        end else if (flag_we && !flag_issue) begin
            if (pend_q != '0) pend_d = pend_q - CNT_ONE;
        end

        if (accept) cond_d = br_cond;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (pend_q == '0 && !flag_we) begin
                        tv_d    = 1'b1;
                        taken_d = cond_eval(br_cond, nzcv_q);
                    end else if (last_we) begin
                        if (FWD_EN) begin
                            tv_d    = 1'b1;
                            taken_d = cond_eval(br_cond, eff_flags);
                        end else begin
                            state_d = ST_RESOLVE;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (last_we) begin
                    if (FWD_EN) begin
                        tv_d    = 1'b1;
                        taken_d = cond_eval(cond_q, eff_flags);
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    tv_d    = 1'b1;
                    taken_d = cond_eval(cond_q, nzcv_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            nzcv_q  <= '0;
            pend_q  <= '0;
            cond_q  <= '0;
            taken_q <= 1'b0;
            tv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nzcv_q  <= nzcv_d;
            pend_q  <= pend_d;
            cond_q  <= cond_d;
            taken_q <= taken_d;
            tv_q    <= tv_d;
            ovf_q   <= ovf_d;
        end
    end

    assign taken_valid = tv_q;
    assign taken       = taken_q;
    assign nzcv        = nzcv_q;
    assign pend_cnt    = pend_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: a forwarding and a non-forwarding instance share stimulus and
// are compared every cycle against a transaction-level reference model.
module tb_cond_flag_unit;

    localparam int PMAX = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       flag_we, negative, zero, carry_out, overflow;
    logic       flag_issue, flush, br_valid;
    logic [3:0] br_cond;

    logic [1:0] br_ready_o, tv_o, tk_o, ovf_o;
    logic [3:0] nzcv_o [2];
    logic [1:0] pend_o [2];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] flags;
        int         cnt;
        bit         ovf;
        bit         waiting;    // branch accepted, older setters still outstanding
        bit         resolving;  // final flags written, result due one cycle later
        logic [3:0] cond;
        bit         taken;
        bit         tv;
    } model_t;

    model_t m [2];

    always #5 clk = ~clk;

    cond_flag_unit #(.PEND_MAX(PMAX), .FWD_EN(1'b1)) u_fwd (
        .clk(clk), .reset(reset), .flag_we(flag_we), .negative(negative), .zero(zero),
        .carry_out(carry_out), .overflow(overflow), .flag_issue(flag_issue), .flush(flush),
        .br_valid(br_valid), .br_cond(br_cond), .br_ready(br_ready_o[0]),
        .taken_valid(tv_o[0]), .taken(tk_o[0]), .nzcv(nzcv_o[0]), .pend_cnt(pend_o[0]),
        .ovf_err(ovf_o[0])
    );

    cond_flag_unit #(.PEND_MAX(PMAX), .FWD_EN(1'b0)) u_nofwd (
        .clk(clk), .reset(reset), .flag_we(flag_we), .negative(negative), .zero(zero),
        .carry_out(carry_out), .overflow(overflow), .flag_issue(flag_issue), .flush(flush),
        .br_valid(br_valid), .br_cond(br_cond), .br_ready(br_ready_o[1]),
        .taken_valid(tv_o[1]), .taken(tk_o[1]), .nzcv(nzcv_o[1]), .pend_cnt(pend_o[1]),
        .ovf_err(ovf_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ARM condition semantics: bits [3:1] pick a base test, bit 0 inverts it (except AL/NV).
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic model_t step(input model_t cur, input bit fwd, input bit rst_i,
                                    input bit we, input bit iss, input bit fl, input bit bv,
                                    input logic [3:0] f, input logic [3:0] bc);
        model_t nx;
        logic [3:0] eff;
        bit last, idle;
        nx = cur;
        if (rst_i) begin
            nx.flags = 4'h0; nx.cnt = 0; nx.ovf = 0; nx.waiting = 0;
            nx.resolving = 0; nx.cond = 4'h0; nx.taken = 0; nx.tv = 0;
            return nx;
        end
        nx.tv = 0;
        eff   = (fwd && we) ? f : cur.flags;
        last  = we && cur.cnt <= 1;
        idle  = !cur.waiting && !cur.resolving;
        if (cur.resolving) begin
            nx.resolving = 0;
            if (!fl) begin
                nx.tv = 1;
                nx.taken = cond_ok(cur.cond, cur.flags);
            end
        end else if (cur.waiting) begin
            if (fl) nx.waiting = 0;
            else if (last) begin
                nx.waiting = 0;
                if (fwd) begin nx.tv = 1; nx.taken = cond_ok(cur.cond, eff); end
                else nx.resolving = 1;
            end
        end else if (idle && !fl && bv) begin
            nx.cond = bc;
            if (cur.cnt == 0 && !we) begin
                nx.tv = 1; nx.taken = cond_ok(bc, cur.flags);
            end else if (last) begin
                if (fwd) begin nx.tv = 1; nx.taken = cond_ok(bc, eff); end
                else nx.resolving = 1;
            end else begin
                nx.waiting = 1;
            end
        end
        if (we) nx.flags = f;
        if (fl) nx.cnt = 0;
        else nx.cnt = cur.cnt + ((iss && !we && cur.cnt < PMAX) ? 1 : 0)
                              - ((we && !iss && cur.cnt > 0) ? 1 : 0);
        nx.ovf = cur.ovf || (iss && !we && cur.cnt == PMAX);
        return nx;
    endfunction

    // Drive one cycle's inputs just after a falling edge, check br_ready, advance the model,
    // then check every registered output at the next falling edge.
    task automatic cycle(input bit rst_i, input bit we, input bit iss, input bit fl,
                         input bit bv, input logic [3:0] f, input logic [3:0] bc);
        reset = rst_i; flag_we = we; {negative, zero, carry_out, overflow} = f;
        flag_issue = iss; flush = fl; br_valid = bv; br_cond = bc;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.br_ready", i), br_ready_o[i],
                  !rst_i && !fl && !m[i].waiting && !m[i].resolving);
            m[i] = step(m[i], i == 0, rst_i, we, iss, fl, bv, f, bc);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.nzcv", i), nzcv_o[i], m[i].flags);
            check($sformatf("u%0d.pend_cnt", i), pend_o[i], m[i].cnt);
            check($sformatf("u%0d.ovf_err", i), ovf_o[i], m[i].ovf);
            check($sformatf("u%0d.taken_valid", i), tv_o[i], m[i].tv);
            check($sformatf("u%0d.taken", i), tk_o[i], m[i].taken);
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 4'h0, 4'h0);
    endtask

    task automatic issue();
        cycle(0, 0, 1, 0, 0, 4'h0, 4'h0);
    endtask

    initial begin
        @(negedge clk);
        cycle(1, 0, 0, 0, 0, 4'h0, 4'h0);
        check("rst.nzcv", nzcv_o[0], 4'h0);
        check("rst.pend", pend_o[0], 0);
        check("rst.tv", tv_o[0], 0);
        check("rst.ovf", ovf_o[0], 0);
        idle();

        // nzcv=0100, no pending setters: EQ taken, NE not taken, one-cycle latency
        cycle(0, 1, 0, 0, 0, 4'b0100, 4'h0);
        cycle(0, 0, 0, 0, 1, 4'h0, 4'h0);
        check("eq.tv", tv_o[0], 1);
        check("eq.taken", tk_o[0], 1);
        check("eq.tv_nofwd", tv_o[1], 1);
        cycle(0, 0, 0, 0, 1, 4'h0, 4'h1);
        check("ne.taken", tk_o[0], 0);
        idle();

        // one setter pending, final write N=1,V=0 arrives with BR LT
        issue();
        cycle(0, 1, 0, 0, 1, 4'b1000, 4'hB);
        check("fwd_lt.tv", tv_o[0], 1);
        check("fwd_lt.taken", tk_o[0], 1);
        check("fwd_lt.nzcv", nzcv_o[0], 4'b1000);
        check("nofwd_lt.tv_early", tv_o[1], 0);
        idle();
        check("nofwd_lt.tv", tv_o[1], 1);
        check("nofwd_lt.taken", tk_o[1], 1);
        check("fwd_lt.single_pulse", tv_o[0], 0);

        // non-forwarding: BR EQ with the final Z=1 write resolves two cycles after accept
        issue();
        cycle(0, 1, 0, 0, 1, 4'b0100, 4'h0);
        check("nofwd_eq.tv_early", tv_o[1], 0);
        idle();
        check("nofwd_eq.tv", tv_o[1], 1);
        check("nofwd_eq.taken", tk_o[1], 1);
        idle();

        // two setters pending, BR GE waits for the second write
        issue();
        issue();
        cycle(0, 0, 0, 0, 1, 4'h0, 4'hA);
        check("ge.wait_ready", br_ready_o[0], 0);
        cycle(0, 1, 0, 0, 0, 4'b1001, 4'h0);
        check("ge.no_early_tv", tv_o[0], 0);
        cycle(0, 1, 0, 0, 0, 4'b0001, 4'h0);
        check("ge.tv", tv_o[0], 1);
        check("ge.taken", tk_o[0], 0);
        idle();
        check("ge.single_pulse", tv_o[0], 0);
        idle();

        // reset while a branch waits on two setters
        issue();
        issue();
        cycle(0, 0, 0, 0, 1, 4'h0, 4'h0);
        check("rstwait.pend", pend_o[0], 2);
        cycle(1, 0, 0, 0, 0, 4'h0, 4'h0);
        check("rstwait.nzcv", nzcv_o[0], 4'h0);
        check("rstwait.pend0", pend_o[0], 0);
        check("rstwait.tv", tv_o[0], 0);
        check("rstwait.ready_low", br_ready_o[0], 0);
        idle();
        check("rstwait.ready_high", br_ready_o[0], 1);

        // flush drops the waiting branch, then saturate the setter count
        issue();
        cycle(0, 0, 0, 0, 1, 4'h0, 4'h3);
        cycle(0, 0, 0, 1, 0, 4'h0, 4'h0);
        check("flush.pend", pend_o[0], 0);
        idle();
        check("flush.no_tv", tv_o[0], 0);
        check("flush.no_tv_nofwd", tv_o[1], 0);
        for (int k = 0; k < 4; k++) issue();
        check("sat.pend", pend_o[0], 3);
        check("sat.ovf", ovf_o[0], 1);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
